// File: rtl/data_mem_responder.sv
// Responder for the memory unit's read/write request channels: byte-addressed little-endian array,
// four-phase en/done handshake with LATENCY-edge response. Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses.
module data_mem_responder #(
  parameter int DEPTH   = 65536,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic [31:0] read_addr,
  input  logic [2:0]  read_byte_num,
  output logic [31:0] read_data,
  output logic        read_done,
  input  logic        write_en,
  input  logic [31:0] write_addr,
  input  logic [2:0]  write_byte_num,
  input  logic [31:0] write_data,
  output logic        write_done,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

`ifdef MEM_ALIGN_CHECK_EN
  localparam logic ALIGN_CHECK = 1'b1;
`else
  localparam logic ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ch_state_e;

  logic [7:0] mem [DEPTH];

  ch_state_e   rd_state_q, rd_state_d;
  ch_state_e   wr_state_q, wr_state_d;
  logic [3:0]  rd_cnt_q, rd_cnt_d;
  logic [3:0]  wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [2:0]  rd_num_q, rd_num_d;
  logic [2:0]  wr_num_q, wr_num_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] read_data_q, read_data_d;
  logic        read_done_q, read_done_d;
  logic        write_done_q, write_done_d;
  logic        err_q, err_d;

  logic          rd_rej, wr_rej;
  logic          wr_commit;
  logic [31:0]   rd_word;
  logic [AW-1:0] rd_idx;
  logic          unused_addr_bits;

  // Width must be 1, 2 or 4; optionally the address must also be width-aligned.
  function automatic logic is_rejected(input logic [2:0] num, input logic [1:0] lsb);
    logic bad_num;
    logic misaligned;
    bad_num    = !(num == 3'd1 || num == 3'd2 || num == 3'd4);
    misaligned = (num == 3'd2 && lsb[0]) || (num == 3'd4 && lsb != 2'b00);
    return bad_num || (ALIGN_CHECK && misaligned);
  endfunction

  assign rd_rej    = is_rejected(rd_num_q, rd_addr_q[1:0]);
  assign wr_rej    = is_rejected(wr_num_q, wr_addr_q[1:0]);
  assign wr_commit = (wr_state_q == BUSY) && (wr_cnt_q == 4'd0) && !wr_rej;

  assign unused_addr_bits = ^{read_addr[31:AW], write_addr[31:AW]};

  // Read assembly sees the array before any same-edge write commits.
  always_comb begin
    rd_word = '0;
    rd_idx  = '0;
    for (int i = 0; i < 4; i++) begin
      rd_idx = rd_addr_q + AW'(i);
      if (3'(i) < rd_num_q) rd_word[8*i +: 8] = mem[rd_idx];
    end
  end

  always_comb begin
    rd_state_d   = rd_state_q;
    rd_cnt_d     = rd_cnt_q;
    rd_addr_d    = rd_addr_q;
    rd_num_d     = rd_num_q;
    read_data_d  = read_data_q;
    read_done_d  = read_done_q;
    wr_state_d   = wr_state_q;
    wr_cnt_d     = wr_cnt_q;
    wr_addr_d    = wr_addr_q;
    wr_num_d     = wr_num_q;
    wr_data_d    = wr_data_q;
    write_done_d = write_done_q;
    err_d        = 1'b0;

    case (rd_state_q)
      IDLE: begin
        if (read_en) begin
          rd_addr_d  = read_addr[AW-1:0];
          rd_num_d   = read_byte_num;
          rd_cnt_d   = CNT_INIT;
          rd_state_d = BUSY;
        end
      end
      BUSY: begin
        if (rd_cnt_q != 4'd0) begin
          rd_cnt_d = rd_cnt_q - 4'd1;
        end else begin
          read_data_d = rd_rej ? 32'd0 : rd_word;
          read_done_d = 1'b1;
          rd_state_d  = DONE;
          if (rd_rej) err_d = 1'b1;
        end
      end
      DONE: begin
        if (!read_en) begin
          read_done_d = 1'b0;
          rd_state_d  = IDLE;
        end
      end
      default: rd_state_d = IDLE;
    endcase

    case (wr_state_q)
      IDLE: begin
        if (write_en) begin
          wr_addr_d  = write_addr[AW-1:0];
          wr_num_d   = write_byte_num;
          wr_data_d  = write_data;
          wr_cnt_d   = CNT_INIT;
          wr_state_d = BUSY;
        end
      end
      BUSY: begin
        if (wr_cnt_q != 4'd0) begin
          wr_cnt_d = wr_cnt_q - 4'd1;
        end else begin
          write_done_d = 1'b1;
          wr_state_d   = DONE;
          if (wr_rej) err_d = 1'b1;
        end
      end
      DONE: begin
        if (!write_en) begin
          write_done_d = 1'b0;
          wr_state_d   = IDLE;
        end
      end
      default: wr_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q   <= IDLE;
      wr_state_q   <= IDLE;
      rd_cnt_q     <= 4'd0;
      wr_cnt_q     <= 4'd0;
      read_data_q  <= 32'd0;
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rd_state_q   <= rd_state_d;
      wr_state_q   <= wr_state_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      read_data_q  <= read_data_d;
      read_done_q  <= read_done_d;
      write_done_q <= write_done_d;
      err_q        <= err_d;
    end
  end

  // Request payload is only meaningful while BUSY, so it carries no reset.
  always_ff @(posedge clk) begin
    rd_addr_q <= rd_addr_d;
    rd_num_q  <= rd_num_d;
    wr_addr_q <= wr_addr_d;
    wr_num_q  <= wr_num_d;
    wr_data_q <= wr_data_d;
  end

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < wr_num_q) mem[wr_addr_q + AW'(i)] <= wr_data_q[8*i +: 8];
      end
    end
  end

  assign read_data  = read_data_q;
  assign read_done  = read_done_q;
  assign write_done = write_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: handshake timing, byte lanes, wrap, read-before-write,
// illegal widths, reset during a pending write. Expectations follow MEM_ALIGN_CHECK_EN when defined.
module tb_data_mem_responder;

  localparam int DEPTH   = 65536;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_en;
  logic [31:0] read_addr;
  logic [2:0]  read_byte_num;
  logic [31:0] read_data;
  logic        read_done;
  logic        write_en;
  logic [31:0] write_addr;
  logic [2:0]  write_byte_num;
  logic [31:0] write_data;
  logic        write_done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk            (clk),
    .rst            (rst),
    .read_en        (read_en),
    .read_addr      (read_addr),
    .read_byte_num  (read_byte_num),
    .read_data      (read_data),
    .read_done      (read_done),
    .write_en       (write_en),
    .write_addr     (write_addr),
    .write_byte_num (write_byte_num),
    .write_data     (write_data),
    .write_done     (write_done),
    .err            (err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one write; inputs are scrambled after acceptance to prove they were latched.
  task automatic run_write(input logic [31:0] a, input logic [2:0] n, input logic [31:0] d,
                           output int lat, output logic err_early, output logic err_done,
                           output logic err_after, output logic done_after);
    @(posedge clk); #1;
    write_addr = a; write_byte_num = n; write_data = d; write_en = 1'b1;
    @(posedge clk); #1;
    write_addr = a ^ 32'h0000_0F0F; write_data = ~d; write_byte_num = 3'd1;
    lat = 0; err_early = 1'b0;
    while (!write_done && lat < 20) begin
      if (err) err_early = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    err_done = err;
    write_en = 1'b0;
    @(posedge clk); #1;
    err_after  = err;
    done_after = write_done;
  endtask

  task automatic run_read(input logic [31:0] a, input logic [2:0] n, output logic [31:0] data,
                          output int lat, output logic err_early, output logic err_done,
                          output logic err_after, output logic done_after);
    @(posedge clk); #1;
    read_addr = a; read_byte_num = n; read_en = 1'b1;
    @(posedge clk); #1;
    read_addr = a ^ 32'h0000_0F0F; read_byte_num = 3'd1;
    lat = 0; err_early = 1'b0;
    while (!read_done && lat < 20) begin
      if (err) err_early = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    data     = read_data;
    err_done = err;
    read_en  = 1'b0;
    @(posedge clk); #1;
    err_after  = err;
    done_after = read_done;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic        e_early, e_done, e_after, d_after;
    logic [31:0] rd;

    rst = 1'b1;
    read_en = 1'b0; read_addr = '0; read_byte_num = '0;
    write_en = 1'b0; write_addr = '0; write_byte_num = '0; write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_read_done", 32'(read_done), 32'd0);
    check_val("rst_write_done", 32'(write_done), 32'd0);
    check_val("rst_read_data", read_data, 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    run_write(32'h10, 3'd4, 32'hDEAD_BEEF, lat, e_early, e_done, e_after, d_after);
    check_val("w10_latency", 32'(lat), 32'(LATENCY));
    check_val("w10_err", 32'({e_early, e_done, e_after}), 32'd0);
    check_val("w10_done_clear", 32'(d_after), 32'd0);

    run_read(32'h10, 3'd4, rd, lat, e_early, e_done, e_after, d_after);
    check_val("r10_data", rd, 32'hDEAD_BEEF);
    check_val("r10_latency", 32'(lat), 32'(LATENCY));
    check_val("r10_err", 32'({e_early, e_done, e_after}), 32'd0);
    check_val("r10_done_clear", 32'(d_after), 32'd0);

    run_read(32'h11, 3'd1, rd, lat, e_early, e_done, e_after, d_after);
    check_val("r11_b1_data", rd, 32'h0000_00BE);
    check_val("r11_b1_err", 32'(e_done), 32'd0);
    run_read(32'h12, 3'd2, rd, lat, e_early, e_done, e_after, d_after);
    check_val("r12_b2_data", rd, 32'h0000_DEAD);
    check_val("r12_b2_err", 32'(e_done), 32'd0);
    run_read(32'h0001_0010, 3'd4, rd, lat, e_early, e_done, e_after, d_after);
    check_val("r_alias_data", rd, 32'hDEAD_BEEF);

    run_write(32'(DEPTH - 1), 3'd2, 32'h0000_1234, lat, e_early, e_done, e_after, d_after);
    run_read(32'(DEPTH - 1), 3'd2, rd, lat, e_early, e_done, e_after, d_after);
`ifdef MEM_ALIGN_CHECK_EN
    check_val("wrap_rd_data", rd, 32'd0);
    check_val("wrap_rd_err", 32'(e_done), 32'd1);
`else
    check_val("wrap_rd_data", rd, 32'h0000_1234);
    check_val("wrap_rd_err", 32'(e_done), 32'd0);
    run_read(32'(DEPTH - 1), 3'd1, rd, lat, e_early, e_done, e_after, d_after);
    check_val("wrap_top_byte", rd, 32'h0000_0034);
    run_read(32'h0, 3'd1, rd, lat, e_early, e_done, e_after, d_after);
    check_val("wrap_low_byte", rd, 32'h0000_0012);
`endif

    run_write(32'h20, 3'd4, 32'h1122_3344, lat, e_early, e_done, e_after, d_after);
    run_write(32'h24, 3'd4, 32'h5566_7788, lat, e_early, e_done, e_after, d_after);

    @(posedge clk); #1;
    read_addr = 32'h20; read_byte_num = 3'd4; read_en = 1'b1;
    write_addr = 32'h20; write_byte_num = 3'd4; write_data = 32'hAABB_CCDD; write_en = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!(read_done && write_done) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val("rw_same_latency", 32'(lat), 32'(LATENCY));
    check_val("rw_same_rd_old", read_data, 32'h1122_3344);
    read_en = 1'b0; write_en = 1'b0;
    @(posedge clk); #1;
    run_read(32'h20, 3'd4, rd, lat, e_early, e_done, e_after, d_after);
    check_val("rw_after_rd_new", rd, 32'hAABB_CCDD);

    run_write(32'h10, 3'd3, 32'h0102_0304, lat, e_early, e_done, e_after, d_after);
    check_val("w_bad3_latency", 32'(lat), 32'(LATENCY));
    check_val("w_bad3_err_early", 32'(e_early), 32'd0);
    check_val("w_bad3_err_done", 32'(e_done), 32'd1);
    check_val("w_bad3_err_after", 32'(e_after), 32'd0);
    run_read(32'h10, 3'd4, rd, lat, e_early, e_done, e_after, d_after);
    check_val("w_bad3_unchanged", rd, 32'hDEAD_BEEF);

    run_read(32'h10, 3'd3, rd, lat, e_early, e_done, e_after, d_after);
    check_val("r_bad3_data", rd, 32'd0);
    check_val("r_bad3_err", 32'({e_early, e_done, e_after}), 32'b010);
    run_read(32'h10, 3'd0, rd, lat, e_early, e_done, e_after, d_after);
    check_val("r_bad0_data", rd, 32'd0);
    check_val("r_bad0_err", 32'(e_done), 32'd1);

    run_read(32'h22, 3'd4, rd, lat, e_early, e_done, e_after, d_after);
`ifdef MEM_ALIGN_CHECK_EN
    check_val("r22_misalign_data", rd, 32'd0);
    check_val("r22_misalign_err", 32'(e_done), 32'd1);
`else
    check_val("r22_misalign_data", rd, 32'h7788_AABB);
    check_val("r22_misalign_err", 32'(e_done), 32'd0);
`endif

    // Read request withdrawn while BUSY: done still pulses for exactly one cycle.
    @(posedge clk); #1;
    read_addr = 32'h10; read_byte_num = 3'd4; read_en = 1'b1;
    @(posedge clk); #1;
    read_en = 1'b0;
    @(posedge clk); #1;
    check_val("drop_done_mid", 32'(read_done), 32'd0);
    @(posedge clk); #1;
    check_val("drop_done_rise", 32'(read_done), 32'd1);
    check_val("drop_data", read_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check_val("drop_done_clear", 32'(read_done), 32'd0);

    run_write(32'h40, 3'd4, 32'h0102_0304, lat, e_early, e_done, e_after, d_after);
    @(posedge clk); #1;
    write_addr = 32'h40; write_byte_num = 3'd4; write_data = 32'hFFFF_FFFF; write_en = 1'b1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check_val("rstbusy_write_done", 32'(write_done), 32'd0);
    check_val("rstbusy_read_data", read_data, 32'd0);
    write_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rstbusy_done_stays", 32'(write_done), 32'd0);
    run_read(32'h40, 3'd4, rd, lat, e_early, e_done, e_after, d_after);
    check_val("rstbusy_target_kept", rd, 32'h0102_0304);
    check_val("rstbusy_rd_latency", 32'(lat), 32'(LATENCY));

    run_write(32'h44, 3'd2, 32'hBEEF_C0DE, lat, e_early, e_done, e_after, d_after);
    check_val("post_rst_w_latency", 32'(lat), 32'(LATENCY));
    run_read(32'h44, 3'd2, rd, lat, e_early, e_done, e_after, d_after);
    check_val("post_rst_rd_data", rd, 32'h0000_C0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
